// File: rtl/wed_fetch_engine_multi.sv
// rtl/wed_fetch_engine_multi.sv - multi-line WED fetch engine with retry and endian swap
//
// Fetches WED_LINES consecutive 128-byte cachelines starting at a base address.
// Each line is issued with tag TAG_BASE+i. Responses and data may return in any
// order. Flushed lines are reissued up to MAX_RETRY times. Every FIELD_BITS
// field is byte-reversed when SWAP_ENDIAN is nonzero.
//
// Ports:
//   clock, rstn                   clock, asynchronous active-low reset
//   enabled_in, start_in          CU enable and single-cycle fetch request
//   wed_address_in                128-byte aligned WED base address
//   cmd_ready_in / cmd_valid_out  read command handshake
//   cmd_address_out, cmd_tag_out  command address and tag
//   rsp_valid_in, rsp_tag_in      response channel
//   rsp_status_in                 00 done, 01 flushed, 1x fault
//   data_valid_in, data_tag_in    read data channel
//   data_in                       read data line
//   wed_valid_out                 one-cycle completion pulse
//   wed_address_out               latched base address
//   wed_payload_out               assembled WED, line 0 in the MSBs
//   busy_out, fault_out           activity and sticky fault flags
module wed_fetch_engine_multi #(
   parameter int WED_LINES      = 2,
   parameter int CACHELINE_BITS = 1024,
   parameter int FIELD_BITS     = 64,
   parameter int SWAP_ENDIAN    = 1,
   parameter int MAX_RETRY      = 3,
   parameter int TAG_BASE       = 0
) (
   input  logic                                clock,
   input  logic                                rstn,
   input  logic                                enabled_in,
   input  logic                                start_in,
   input  logic [63:0]                         wed_address_in,
   input  logic                                cmd_ready_in,
   output logic                                cmd_valid_out,
   output logic [63:0]                         cmd_address_out,
   output logic [7:0]                          cmd_tag_out,
   input  logic                                rsp_valid_in,
   input  logic [7:0]                          rsp_tag_in,
   input  logic [1:0]                          rsp_status_in,
   input  logic                                data_valid_in,
   input  logic [7:0]                          data_tag_in,
   input  logic [CACHELINE_BITS-1:0]           data_in,
   output logic                                wed_valid_out,
   output logic [63:0]                         wed_address_out,
   output logic [WED_LINES*CACHELINE_BITS-1:0] wed_payload_out,
   output logic                                busy_out,
   output logic                                fault_out
);

   localparam int IW = (WED_LINES > 1) ? $clog2(WED_LINES) : 1;
   localparam int RW = $clog2(MAX_RETRY + 1);
   localparam int PW = WED_LINES * CACHELINE_BITS;
   localparam logic [WED_LINES-1:0] ALL_LINES = '1;

   typedef enum logic [2:0] {
      WED_RESET,
      WED_IDLE,
      WED_REQ,
      WED_WAITING_FOR_REQUEST,
      WED_DONE_REQ,
      WED_FAULT
   } state_t;

   state_t                state_q, state_d;
   logic [WED_LINES-1:0]  need_q, need_d;
   logic [WED_LINES-1:0]  out_q, out_d;
   logic [WED_LINES-1:0]  got_q, got_d;
   logic [WED_LINES-1:0]  done_q, done_d;
   logic [RW-1:0]         retry_q [WED_LINES];
   logic [RW-1:0]         retry_d [WED_LINES];
   logic [63:0]           addr_q, addr_d;
   logic [PW-1:0]         payload_q;

   logic [IW-1:0] cmd_idx;
   logic          cmd_fire;
   logic          accept;
   logic [8:0]    rsp_off, data_off;
   logic [IW-1:0] rsp_idx, data_idx;
   logic          rsp_hit, data_hit, rsp_flush, data_wr;
   logic          fault_ev;

   function automatic logic [CACHELINE_BITS-1:0] swap_line(input logic [CACHELINE_BITS-1:0] d);
      logic [CACHELINE_BITS-1:0] r;
      r = d;
      if (SWAP_ENDIAN != 0) begin
         for (int f = 0; f < CACHELINE_BITS / FIELD_BITS; f++) begin
            for (int b = 0; b < FIELD_BITS / 8; b++) begin
               r[f*FIELD_BITS + b*8 +: 8] = d[f*FIELD_BITS + (FIELD_BITS/8 - 1 - b)*8 +: 8];
            end
         end
      end
      return r;
   endfunction

   // Lowest pending line wins the command slot; the scan runs high to low so
   // the last assignment is the lowest index.
   always_comb begin
      cmd_idx = '0;
      for (int i = WED_LINES - 1; i >= 0; i--) begin
         if (need_q[i]) cmd_idx = IW'(i);
      end
   end

   assign cmd_valid_out   = (state_q == WED_REQ) && (|need_q);
   assign cmd_fire        = cmd_valid_out && cmd_ready_in;
   assign cmd_address_out = cmd_valid_out ? (addr_q + (64'(cmd_idx) << 7)) : 64'd0;
   assign cmd_tag_out     = cmd_valid_out ? (8'(TAG_BASE) + 8'(cmd_idx)) : 8'd0;

   // Tag offsets are computed with a guard bit so tags below TAG_BASE wrap to
   // large values and fall out of range.
   assign accept   = (state_q == WED_REQ) || (state_q == WED_WAITING_FOR_REQUEST);
   assign rsp_off  = {1'b0, rsp_tag_in} - 9'(TAG_BASE);
   assign data_off = {1'b0, data_tag_in} - 9'(TAG_BASE);
   assign rsp_idx  = rsp_off[IW-1:0];
   assign data_idx = data_off[IW-1:0];
   assign rsp_hit  = accept && rsp_valid_in && (rsp_off < 9'(WED_LINES)) && out_q[rsp_idx];
   assign data_hit = accept && data_valid_in && (data_off < 9'(WED_LINES)) && out_q[data_idx];
   assign rsp_flush = rsp_hit && (rsp_status_in == 2'b01);
   // A flush on the same line in the same cycle discards the data beat.
   assign data_wr  = data_hit && !(rsp_flush && (rsp_idx == data_idx));

   always_comb begin
      state_d  = state_q;
      need_d   = need_q;
      out_d    = out_q;
      got_d    = got_q;
      done_d   = done_q;
      retry_d  = retry_q;
      addr_d   = addr_q;
      fault_ev = 1'b0;
      case (state_q)
         WED_RESET: state_d = WED_IDLE;
         WED_IDLE: begin
            if (start_in && enabled_in) begin
               addr_d = wed_address_in;
               need_d = ALL_LINES;
               out_d  = '0;
               got_d  = '0;
               done_d = '0;
               for (int i = 0; i < WED_LINES; i++) retry_d[i] = '0;
               state_d = WED_REQ;
            end
         end
         WED_REQ, WED_WAITING_FOR_REQUEST: begin
            if (cmd_fire) begin
               need_d[cmd_idx] = 1'b0;
               out_d[cmd_idx]  = 1'b1;
            end
            if (data_wr) got_d[data_idx] = 1'b1;
            if (rsp_hit) begin
               case (rsp_status_in)
                  2'b00: begin
                     done_d[rsp_idx] = 1'b1;
                     out_d[rsp_idx]  = 1'b0;
                  end
                  2'b01: begin
                     if (retry_q[rsp_idx] < RW'(MAX_RETRY)) begin
                        retry_d[rsp_idx] = retry_q[rsp_idx] + RW'(1);
                        out_d[rsp_idx]   = 1'b0;
                        got_d[rsp_idx]   = 1'b0;
                        done_d[rsp_idx]  = 1'b0;
                        need_d[rsp_idx]  = 1'b1;
                     end else begin
                        fault_ev = 1'b1;
                     end
                  end
                  default: fault_ev = 1'b1;
               endcase
            end
            if (fault_ev) begin
               state_d = WED_FAULT;
            end else if (state_q == WED_REQ) begin
               if (need_d == '0) state_d = WED_WAITING_FOR_REQUEST;
            end else if (need_d != '0) begin
               state_d = WED_REQ;
            end else if ((got_q == ALL_LINES) && (done_q == ALL_LINES)) begin
               state_d = WED_DONE_REQ;
            end
         end
         WED_DONE_REQ: state_d = WED_IDLE;
         WED_FAULT:    state_d = WED_FAULT;
         default:      state_d = WED_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         state_q <= WED_RESET;
         need_q  <= '0;
         out_q   <= '0;
         got_q   <= '0;
         done_q  <= '0;
         addr_q  <= '0;
         for (int i = 0; i < WED_LINES; i++) retry_q[i] <= '0;
      end else begin
         state_q <= state_d;
         need_q  <= need_d;
         out_q   <= out_d;
         got_q   <= got_d;
         done_q  <= done_d;
         addr_q  <= addr_d;
         retry_q <= retry_d;
      end
   end

   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         payload_q <= '0;
      end else if (data_wr) begin
         payload_q[(WED_LINES - 1 - int'(data_idx)) * CACHELINE_BITS +: CACHELINE_BITS] <= swap_line(data_in);
      end
   end

   assign wed_valid_out   = (state_q == WED_DONE_REQ);
   assign wed_address_out = addr_q;
   assign wed_payload_out = payload_q;
   assign busy_out        = (state_q != WED_IDLE) && (state_q != WED_RESET);
   assign fault_out       = (state_q == WED_FAULT);

endmodule

// File: tb/tb_wed_fetch_engine_multi.sv
// tb/tb_wed_fetch_engine_multi.sv - directed self-checking bench for wed_fetch_engine_multi
module tb_wed_fetch_engine_multi;

   logic          clock;
   logic          rstn;
   logic          enabled_in;
   logic          start_in;
   logic [63:0]   wed_address_in;
   logic          cmd_ready_in;
   logic          rsp_valid_in;
   logic [7:0]    rsp_tag_in;
   logic [1:0]    rsp_status_in;
   logic          data_valid_in;
   logic [7:0]    data_tag_in;
   logic [1023:0] data_in;

   logic          cmd_valid_out, cmd_valid_ns;
   logic [63:0]   cmd_address_out, cmd_address_ns;
   logic [7:0]    cmd_tag_out, cmd_tag_ns;
   logic          wed_valid_out, wed_valid_ns;
   logic [63:0]   wed_address_out, wed_address_ns;
   logic [2047:0] wed_payload_out, wed_payload_ns;
   logic          busy_out, busy_ns;
   logic          fault_out, fault_ns;

   int pass_cnt = 0;
   int check_cnt = 0;

   logic [1023:0] d0, d1, e0, e1;

   wed_fetch_engine_multi dut (
      .clock(clock), .rstn(rstn), .enabled_in(enabled_in), .start_in(start_in),
      .wed_address_in(wed_address_in), .cmd_ready_in(cmd_ready_in),
      .cmd_valid_out(cmd_valid_out), .cmd_address_out(cmd_address_out), .cmd_tag_out(cmd_tag_out),
      .rsp_valid_in(rsp_valid_in), .rsp_tag_in(rsp_tag_in), .rsp_status_in(rsp_status_in),
      .data_valid_in(data_valid_in), .data_tag_in(data_tag_in), .data_in(data_in),
      .wed_valid_out(wed_valid_out), .wed_address_out(wed_address_out),
      .wed_payload_out(wed_payload_out), .busy_out(busy_out), .fault_out(fault_out)
   );

   wed_fetch_engine_multi #(.SWAP_ENDIAN(0)) dut_ns (
      .clock(clock), .rstn(rstn), .enabled_in(enabled_in), .start_in(start_in),
      .wed_address_in(wed_address_in), .cmd_ready_in(cmd_ready_in),
      .cmd_valid_out(cmd_valid_ns), .cmd_address_out(cmd_address_ns), .cmd_tag_out(cmd_tag_ns),
      .rsp_valid_in(rsp_valid_in), .rsp_tag_in(rsp_tag_in), .rsp_status_in(rsp_status_in),
      .data_valid_in(data_valid_in), .data_tag_in(data_tag_in), .data_in(data_in),
      .wed_valid_out(wed_valid_ns), .wed_address_out(wed_address_ns),
      .wed_payload_out(wed_payload_ns), .busy_out(busy_ns), .fault_out(fault_ns)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #400000;
      $display("FAIL global_timeout got running want finished");
      $fatal(1);
   end

   // One cycle: returns 1 time unit after the falling edge.
   task automatic step;
      @(negedge clock);
      #1;
   endtask

   task automatic beat(input logic dv, input logic [7:0] dt, input logic [1023:0] d,
                       input logic rv, input logic [7:0] rt, input logic [1:0] st);
      data_valid_in = dv;
      data_tag_in   = dt;
      data_in       = d;
      rsp_valid_in  = rv;
      rsp_tag_in    = rt;
      rsp_status_in = st;
      step;
      data_valid_in = 1'b0;
      rsp_valid_in  = 1'b0;
   endtask

   task automatic do_start(input logic [63:0] a);
      start_in       = 1'b1;
      enabled_in     = 1'b1;
      wed_address_in = a;
      step;
      start_in = 1'b0;
   endtask

   task automatic wait_wed(input int max, output int n);
      n = -1;
      for (int k = 1; k <= max; k++) begin
         step;
         if (wed_valid_out === 1'b1) begin
            n = k;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rstn = 1'b0;
      step;
      step;
      check_cnt++;
      if ({cmd_valid_out, wed_valid_out, busy_out, fault_out, cmd_address_out, cmd_tag_out, wed_address_out} !== 140'd0)
         $display("FAIL reset_outputs got %b%b%b%b %h %h %h want zeros", cmd_valid_out, wed_valid_out, busy_out,
                  fault_out, cmd_address_out, cmd_tag_out, wed_address_out);
      else pass_cnt++;
      check_cnt++;
      if (wed_payload_out !== 2048'd0) $display("FAIL reset_payload got nonzero want 0");
      else pass_cnt++;
      rstn = 1'b1;
      step;
      enabled_in = 1'b0;
      start_in   = 1'b1;
      step;
      start_in = 1'b0;
      check_cnt++;
      if ({busy_out, cmd_valid_out} !== 2'b00)
         $display("FAIL start_disabled got busy=%b cmd_valid=%b want 0 0", busy_out, cmd_valid_out);
      else pass_cnt++;
   endtask

   task automatic test_basic;
      int n;
      cmd_ready_in = 1'b1;
      do_start(64'h1000);
      check_cnt++;
      if ({cmd_valid_out, cmd_address_out, cmd_tag_out, busy_out} !== {1'b1, 64'h1000, 8'd0, 1'b1})
         $display("FAIL basic_cmd0 got %b %h %h want 1 1000 00", cmd_valid_out, cmd_address_out, cmd_tag_out);
      else pass_cnt++;
      step;
      check_cnt++;
      if ({cmd_valid_out, cmd_address_out, cmd_tag_out} !== {1'b1, 64'h1080, 8'd1})
         $display("FAIL basic_cmd1 got %b %h %h want 1 1080 01", cmd_valid_out, cmd_address_out, cmd_tag_out);
      else pass_cnt++;
      step;
      check_cnt++;
      if (cmd_valid_out !== 1'b0) $display("FAIL basic_cmd_idle got %b want 0", cmd_valid_out);
      else pass_cnt++;
      beat(1'b1, 8'd0, d0, 1'b1, 8'd0, 2'b00);
      beat(1'b1, 8'd1, d1, 1'b1, 8'd1, 2'b00);
      wait_wed(10, n);
      check_cnt++;
      if (n !== 1) $display("FAIL basic_latency got %0d want 1", n);
      else pass_cnt++;
      check_cnt++;
      if (wed_payload_out[2047:1024] !== e0) $display("FAIL basic_line0 got %h want %h", wed_payload_out[2047:1024], e0);
      else pass_cnt++;
      check_cnt++;
      if (wed_payload_out[1023:0] !== e1) $display("FAIL basic_line1 got %h want %h", wed_payload_out[1023:0], e1);
      else pass_cnt++;
      check_cnt++;
      if (wed_address_out !== 64'h1000) $display("FAIL basic_address got %h want 1000", wed_address_out);
      else pass_cnt++;
      step;
      check_cnt++;
      if ({wed_valid_out, busy_out} !== 2'b00)
         $display("FAIL basic_pulse_end got valid=%b busy=%b want 0 0", wed_valid_out, busy_out);
      else pass_cnt++;
   endtask

   task automatic test_out_of_order;
      int n;
      do_start(64'h2000);
      step;
      step;
      beat(1'b1, 8'd1, d0, 1'b1, 8'd1, 2'b00);
      check_cnt++;
      if (wed_valid_out !== 1'b0) $display("FAIL ooo_early_valid_a got %b want 0", wed_valid_out);
      else pass_cnt++;
      step;
      check_cnt++;
      if ({wed_valid_out, busy_out} !== 2'b01)
         $display("FAIL ooo_early_valid_b got valid=%b busy=%b want 0 1", wed_valid_out, busy_out);
      else pass_cnt++;
      beat(1'b1, 8'd0, d1, 1'b0, 8'd0, 2'b00);
      beat(1'b0, 8'd0, d1, 1'b1, 8'd0, 2'b00);
      wait_wed(10, n);
      check_cnt++;
      if (n !== 1) $display("FAIL ooo_latency got %0d want 1", n);
      else pass_cnt++;
      check_cnt++;
      if (wed_payload_out !== {e1, e0}) $display("FAIL ooo_payload got line0 %h want %h", wed_payload_out[2047:1024], e1);
      else pass_cnt++;
      step;
   endtask

   task automatic test_retry;
      int n;
      do_start(64'h1000);
      step;
      step;
      // data and flush on the same line in one cycle: the flush wins
      beat(1'b1, 8'd0, d0, 1'b1, 8'd0, 2'b01);
      check_cnt++;
      if ({cmd_valid_out, cmd_address_out, cmd_tag_out} !== {1'b1, 64'h1000, 8'd0})
         $display("FAIL retry_reissue1 got %b %h %h want 1 1000 00", cmd_valid_out, cmd_address_out, cmd_tag_out);
      else pass_cnt++;
      step;
      check_cnt++;
      if (cmd_valid_out !== 1'b0) $display("FAIL retry_idle1 got %b want 0", cmd_valid_out);
      else pass_cnt++;
      beat(1'b0, 8'd0, d0, 1'b1, 8'd0, 2'b01);
      check_cnt++;
      if ({cmd_valid_out, cmd_address_out, cmd_tag_out} !== {1'b1, 64'h1000, 8'd0})
         $display("FAIL retry_reissue2 got %b %h %h want 1 1000 00", cmd_valid_out, cmd_address_out, cmd_tag_out);
      else pass_cnt++;
      step;
      beat(1'b1, 8'd0, d1, 1'b1, 8'd0, 2'b00);
      beat(1'b1, 8'd1, d0, 1'b1, 8'd1, 2'b00);
      wait_wed(10, n);
      check_cnt++;
      if (n !== 1) $display("FAIL retry_latency got %0d want 1", n);
      else pass_cnt++;
      check_cnt++;
      if ({fault_out, wed_payload_out} !== {1'b0, e1, e0})
         $display("FAIL retry_result got fault=%b line0 %h want 0 %h", fault_out, wed_payload_out[2047:1024], e1);
      else pass_cnt++;
      step;
   endtask

   task automatic test_back_to_back_backpressure;
      int n;
      cmd_ready_in = 1'b0;
      do_start(64'h4000);
      for (int k = 0; k < 5; k++) begin
         check_cnt++;
         if ({cmd_valid_out, cmd_address_out, cmd_tag_out} !== {1'b1, 64'h4000, 8'd0})
            $display("FAIL bp_hold0 cycle %0d got %b %h %h want 1 4000 00", k, cmd_valid_out, cmd_address_out, cmd_tag_out);
         else pass_cnt++;
         step;
      end
      cmd_ready_in = 1'b1;
      step;
      cmd_ready_in = 1'b0;
      check_cnt++;
      if ({cmd_valid_out, cmd_address_out, cmd_tag_out} !== {1'b1, 64'h4080, 8'd1})
         $display("FAIL bp_cmd1 got %b %h %h want 1 4080 01", cmd_valid_out, cmd_address_out, cmd_tag_out);
      else pass_cnt++;
      step;
      check_cnt++;
      if ({cmd_valid_out, cmd_address_out, cmd_tag_out} !== {1'b1, 64'h4080, 8'd1})
         $display("FAIL bp_hold1 got %b %h %h want 1 4080 01", cmd_valid_out, cmd_address_out, cmd_tag_out);
      else pass_cnt++;
      cmd_ready_in = 1'b1;
      step;
      check_cnt++;
      if (cmd_valid_out !== 1'b0) $display("FAIL bp_done got %b want 0", cmd_valid_out);
      else pass_cnt++;
      beat(1'b1, 8'd1, d1, 1'b1, 8'd1, 2'b00);
      beat(1'b1, 8'd0, d0, 1'b1, 8'd0, 2'b00);
      wait_wed(10, n);
      check_cnt++;
      if (n !== 1) $display("FAIL bp_latency got %0d want 1", n);
      else pass_cnt++;
      step;
   endtask

   task automatic test_fault;
      do_start(64'h5000);
      step;
      step;
      beat(1'b1, 8'd0, d0, 1'b1, 8'd0, 2'b00);
      for (int k = 1; k <= 3; k++) begin
         beat(1'b0, 8'd0, d0, 1'b1, 8'd1, 2'b01);
         check_cnt++;
         if ({cmd_valid_out, cmd_address_out, cmd_tag_out, fault_out} !== {1'b1, 64'h5080, 8'd1, 1'b0})
            $display("FAIL fault_reissue %0d got %b %h %h f=%b want 1 5080 01 0", k, cmd_valid_out, cmd_address_out,
                     cmd_tag_out, fault_out);
         else pass_cnt++;
         step;
      end
      beat(1'b0, 8'd0, d0, 1'b1, 8'd1, 2'b01);
      check_cnt++;
      if ({fault_out, cmd_valid_out, busy_out} !== 3'b101)
         $display("FAIL fault_enter got f=%b cmd=%b busy=%b want 1 0 1", fault_out, cmd_valid_out, busy_out);
      else pass_cnt++;
      start_in = 1'b1;
      step;
      start_in = 1'b0;
      step;
      check_cnt++;
      if ({fault_out, cmd_valid_out, busy_out, wed_valid_out} !== 4'b1010)
         $display("FAIL fault_sticky got f=%b cmd=%b busy=%b valid=%b want 1 0 1 0", fault_out, cmd_valid_out,
                  busy_out, wed_valid_out);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid;
      int n;
      rstn = 1'b0;
      step;
      rstn = 1'b1;
      step;
      do_start(64'h6000);
      step;
      rstn = 1'b0;
      #1;
      check_cnt++;
      if ({cmd_valid_out, busy_out, fault_out, wed_address_out} !== 67'd0)
         $display("FAIL midreset_async got cmd=%b busy=%b f=%b addr=%h want zeros", cmd_valid_out, busy_out,
                  fault_out, wed_address_out);
      else pass_cnt++;
      step;
      check_cnt++;
      if (wed_payload_out !== 2048'd0) $display("FAIL midreset_payload got nonzero want 0");
      else pass_cnt++;
      rstn = 1'b1;
      beat(1'b1, 8'd0, d0, 1'b1, 8'd0, 2'b00);
      step;
      check_cnt++;
      if ({busy_out, cmd_valid_out, wed_valid_out, fault_out} !== 4'b0000)
         $display("FAIL midreset_stale got busy=%b cmd=%b valid=%b f=%b want 0 0 0 0", busy_out, cmd_valid_out,
                  wed_valid_out, fault_out);
      else pass_cnt++;
      do_start(64'h7000);
      check_cnt++;
      if ({cmd_valid_out, cmd_address_out, cmd_tag_out} !== {1'b1, 64'h7000, 8'd0})
         $display("FAIL midreset_cmd0 got %b %h %h want 1 7000 00", cmd_valid_out, cmd_address_out, cmd_tag_out);
      else pass_cnt++;
      step;
      step;
      beat(1'b1, 8'd0, d0, 1'b1, 8'd0, 2'b00);
      beat(1'b1, 8'd1, d1, 1'b1, 8'd1, 2'b00);
      wait_wed(10, n);
      check_cnt++;
      if (n !== 1) $display("FAIL midreset_latency got %0d want 1", n);
      else pass_cnt++;
      check_cnt++;
      if (wed_payload_out !== {e0, e1}) $display("FAIL midreset_payload_swap got line0 %h want %h", wed_payload_out[2047:1024], e0);
      else pass_cnt++;
      check_cnt++;
      if (wed_payload_ns[2047:1024] !== d0) $display("FAIL noswap_line0 got %h want %h", wed_payload_ns[2047:1024], d0);
      else pass_cnt++;
      check_cnt++;
      if ({wed_valid_ns, wed_payload_ns[1023:0]} !== {1'b1, d1})
         $display("FAIL noswap_line1 got %b %h want 1 %h", wed_valid_ns, wed_payload_ns[1023:0], d1);
      else pass_cnt++;
      step;
   endtask

   initial begin
      d0 = {64'h0102030405060708, {14{64'h0}}, 64'h1122334455667788};
      e0 = {64'h0807060504030201, {14{64'h0}}, 64'h8877665544332211};
      d1 = {64'hA0A1A2A3A4A5A6A7, {15{64'h0}}};
      e1 = {64'hA7A6A5A4A3A2A1A0, {15{64'h0}}};
      rstn           = 1'b0;
      enabled_in     = 1'b0;
      start_in       = 1'b0;
      wed_address_in = 64'd0;
      cmd_ready_in   = 1'b0;
      rsp_valid_in   = 1'b0;
      rsp_tag_in     = 8'd0;
      rsp_status_in  = 2'b00;
      data_valid_in  = 1'b0;
      data_tag_in    = 8'd0;
      data_in        = '0;
      test_reset;
      test_basic;
      test_out_of_order;
      test_retry;
      test_back_to_back_backpressure;
      test_fault;
      test_reset_mid;
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
